alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single 64-bit ALU between two requesters: requester 0 is the integer execute path, requester 1 is the address/branch-compare path. It arbitrates round-robin, registers the winning operation into an issue stage that drives the ALU, and captures the ALU result into a response stage. The response is routed back to the requester that issued it. The ALU sits outside this block, and the arbiter owns its input ports.

## Interface
Parameters:
- `XLEN`, 64: operand and result width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid[1:0]`  in  2  requester i presents an operation.
- `req_ready[1:0]`  out  2  requester i's operation is accepted this cycle.
- `req_op0`, `req_op1`  in  4 each  ALUop per requester: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  XLEN each  operands.
- `rsp_valid[1:0]`  out  2  result for requester i is present.
- `rsp_ready[1:0]`  in  2  requester i takes its result.
- `rsp_data`  out  XLEN  result, shared bus, qualified by `rsp_valid`.
- `rsp_zero`  out  1  ALU zero flag of the result.
- `rsp_err`  out  1  illegal opcode; see Configuration.
- `alu_in1`, `alu_in2`  out  XLEN  to ALU.
- `alu_op`  out  4  to ALU.
- `alu_out`  in  XLEN  from ALU.
- `alu_zflag`  in  1  from ALU.

## Operation
- **Issue stage S1** holds: `s1_valid`, op, a, b, `s1_id`.
- **ALU drive:** `alu_in1`/`alu_in2`/`alu_op` are driven from S1 at all times, with no combinational path from `req_*`.
- **Response stage S2** holds: `s2_valid`, data, zero, err, `s2_id`. `rsp_valid[i] = s2_valid & (s2_id == i)`.
- **S2 advance:** `adv2 = s2_valid ? (rsp_ready[s2_id] & rsp_valid[s2_id]) : 1`.
- **S2 load:** S2 loads from S1/ALU when `adv2` is true.
  - If S1 is empty, `s2_valid` clears, but only when S2's content is consumed or was empty.
- **S1 advance:** `adv1 = !s1_valid | adv2`.
- **Arbitration:** only when `adv1` is true.
  - If exactly one requester is valid, it is granted.
  - If both are valid, grant goes to the requester not granted last (pointer `last`).
  - `last` updates only on an actual grant.
- **Ready:** `req_ready[i]` is 1 only for the granted requester, and only when `adv1` is true. It is combinational from `req_valid`, `adv1` and `last`. At most one bit is set.
- **Handshake rules:**
  - A requester holds `valid` and its operands stable until `ready`.
  - A requester must not drop `valid` before `ready`.
  - `rsp_data`, `rsp_zero` and `rsp_err` are stable while `rsp_valid` is high and `rsp_ready` is low.
- **Width:** all arithmetic is XLEN-bit and performed in the ALU. The arbiter does no arithmetic and no extension.

## Timing
- **Reset values:**
  - `s1_valid=0`, `s2_valid=0`.
  - `last=1`, so requester 0 wins the first contention.
  - `req_ready=0`, `rsp_valid=0`.
  - `rsp_data=0`, `rsp_zero=0`, `rsp_err=0`.
  - `alu_op=0000`, `alu_in1=0`, `alu_in2=0`.
- **Reset mid-operation:** a reset during operation discards S1 and S2 contents, with no response delivered.
- **Latency:** handshake at edge t, S1 loaded at t, `rsp_valid` high in the cycle after edge t+1 (2 cycles).
- **Throughput:** one operation per cycle with no backpressure.
- **Backpressure:**
  - `rsp_ready[s2_id]=0` stalls S2.
  - S1 stalls if it is full.
  - `req_ready` drops to 0 for both requesters in the same cycle.
  - Maximum occupancy is 2 operations.
- **Simultaneous events:** S2 drain and S1 load in the same cycle is allowed. An S1→S2 transfer plus a new grant into S1 in the same cycle is allowed.
- **Response ordering:** in issue order. Requester i's `rsp_valid[i]` never asserts for the other requester's operation.

## Configuration
- **With `ALU_ARB_OPCHECK_EN` defined:**
  - At S2 load, an op outside {0000, 0001, 0010, 0110, 0111, 1100} sets `rsp_err=1`, forces data to 0 and forces zero to 1. The ALU X output is never captured.
  - The response is still delivered and counts as a normal completion.
- **Without it:**
  - `rsp_err` is tied to 0.
  - `alu_out`/`alu_zflag` are captured unconditionally, including X for undefined ops.

## Structure
- **Shared package `alu_pkg`:**
  - ALUop localparams: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`.
  - Typedef `alu_op_t` (logic [3:0]).
  - Function `alu_op_legal()`.
- **Sub-module `rr_arb2`:** the combinational 2-way round-robin grant logic, taking `valid[1:0]`, `en` and `last` and producing `gnt[1:0]`. The `last` register stays in `alu_arbiter`.

## Test plan
- **Single ADD:** requester 0 ADD a=5, b=7 → `req_ready[0]` in the same cycle; `rsp_valid[0]` 2 cycles later with data=12, zero=0.
- **Contention:** both requesters valid continuously, 4 ops each → grants alternate 0,1,0,1,…; responses return in that order with correct per-id routing.
- **Backpressure:**
  - Sequence: requester 1 issues SUB 9−9, then `rsp_ready[1]=0` for 3 cycles while 2 more ops are offered.
  - Expected: data=0, zero=1 held stable; S1 fills; `req_ready=00` until release; no op is lost or duplicated.
- **Streaming:** back-to-back AND, OR, SLT(3,8), NOR(0,0) from requester 0 with `rsp_ready` always 1 → results 1/cycle; SLT=1; NOR=all-ones.
- **Illegal opcode (`ALU_ARB_OPCHECK_EN`):** op=0011 → `rsp_err=1`, data=0, zero=1. The same op with the macro undefined → `rsp_err=0`.
- **Reset mid-flight:** assert `reset` with S1 and S2 both full → next cycle all valid/ready outputs 0; requester 0 wins the first post-reset contention.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU opcode encodings and legality check shared by the alu_arbiter slice.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_SLT = 4'b0111;
  localparam alu_op_t ALU_NOR = 4'b1100;

  function automatic logic alu_op_legal(input alu_op_t op);
    logic ok_s;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: ok_s = 1'b1;
      default: ok_s = 1'b0;
    endcase
    return ok_s;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of alu_arbiter. slave = the arbiter,
// master = the requesters plus the external ALU.
interface alu_arbiter_if import alu_pkg::*; #(parameter int XLEN = 64) ();

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  alu_op_t         req_op0;
  alu_op_t         req_op1;
  logic [XLEN-1:0] req_a0;
  logic [XLEN-1:0] req_b0;
  logic [XLEN-1:0] req_a1;
  logic [XLEN-1:0] req_b1;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_zero;
  logic            rsp_err;
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  alu_op_t         alu_op;
  logic [XLEN-1:0] alu_out;
  logic            alu_zflag;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    input  rsp_ready, alu_out, alu_zflag,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
    output alu_in1, alu_in2, alu_op
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    output rsp_ready, alu_out, alu_zflag,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
    input  alu_in1, alu_in2, alu_op
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, contention goes to the
// requester that did not win last. No grant at all while en is low.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       last,
  output logic [1:0] gnt
);

  // grant decode
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU between two requesters through an
// issue stage (S1) and a response stage (S2). Define ALU_ARB_OPCHECK_EN to flag illegal opcodes.
module alu_arbiter import alu_pkg::*; #(parameter int XLEN = 64) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  logic            s1_valid_r;
  alu_op_t         s1_op_r;
  logic [XLEN-1:0] s1_a_r;
  logic [XLEN-1:0] s1_b_r;
  logic            s1_id_r;
  logic            s2_valid_r;
  logic [XLEN-1:0] s2_data_r;
  logic            s2_zero_r;
  logic            s2_err_r;
  logic            s2_id_r;
  logic            last_r;
  logic            adv1_s;
  logic            adv2_s;
  logic [1:0]      gnt_s;
  logic [XLEN-1:0] ld_data_s;
  logic            ld_zero_s;
  logic            ld_err_s;

  // S2 moves when empty or when its owner takes the result
  always_comb begin
    adv2_s = 1'b1;
    if (s2_valid_r) begin
      adv2_s = bus.rsp_ready[s2_id_r];
    end else begin
      adv2_s = 1'b1;
    end
  end

  assign adv1_s = ~s1_valid_r | adv2_s;

  // Grants are suppressed during reset so req_ready reads 0 throughout it.
  rr_arb2 u_arb (
    .valid (bus.req_valid),
    .en    (adv1_s & ~reset),
    .last  (last_r),
    .gnt   (gnt_s)
  );

  assign bus.req_ready = gnt_s;

  // result captured into S2: raw ALU output, or the forced error response
  always_comb begin
    ld_data_s = bus.alu_out;
    ld_zero_s = bus.alu_zflag;
    ld_err_s  = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
    if (!alu_op_legal(s1_op_r)) begin
      ld_data_s = {XLEN{1'b0}};
      ld_zero_s = 1'b1;
      ld_err_s  = 1'b1;
    end else begin
      ld_data_s = bus.alu_out;
      ld_zero_s = bus.alu_zflag;
      ld_err_s  = 1'b0;
    end
`endif
  end

  // issue stage and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= ALU_AND;
      s1_a_r     <= {XLEN{1'b0}};
      s1_b_r     <= {XLEN{1'b0}};
      s1_id_r    <= 1'b0;
      last_r     <= 1'b1;
    end else if (adv1_s) begin
      s1_valid_r <= |gnt_s;
      if (gnt_s[1]) begin
        s1_op_r <= bus.req_op1;
        s1_a_r  <= bus.req_a1;
        s1_b_r  <= bus.req_b1;
        s1_id_r <= 1'b1;
        last_r  <= 1'b1;
      end else if (gnt_s[0]) begin
        s1_op_r <= bus.req_op0;
        s1_a_r  <= bus.req_a0;
        s1_b_r  <= bus.req_b0;
        s1_id_r <= 1'b0;
        last_r  <= 1'b0;
      end
    end
  end

  // response stage; payload only reloads when S1 actually hands over an op
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {XLEN{1'b0}};
      s2_zero_r  <= 1'b0;
      s2_err_r   <= 1'b0;
      s2_id_r    <= 1'b0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r <= ld_data_s;
        s2_zero_r <= ld_zero_s;
        s2_err_r  <= ld_err_s;
        s2_id_r   <= s1_id_r;
      end
    end
  end

  assign bus.rsp_valid = {s2_valid_r & s2_id_r, s2_valid_r & ~s2_id_r};
  assign bus.rsp_data  = s2_data_r;
  assign bus.rsp_zero  = s2_zero_r;
  assign bus.rsp_err   = s2_err_r;
  assign bus.alu_in1   = s1_a_r;
  assign bus.alu_in2   = s1_b_r;
  assign bus.alu_op    = s1_op_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: queue-fed requesters, a behavioural ALU,
// and a cycle-level scoreboard built from the arbitration and latency rules.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int XLEN = 64;

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } op_t;

  typedef struct {
    logic            id;
    logic [XLEN-1:0] data;
    logic            zero;
    logic            err;
    bit              xdata;
    int              vis;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if #(.XLEN(XLEN)) bus ();
  alu_arbiter #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  op_t  src0[$];
  op_t  src1[$];
  exp_t sb[$];
  int   gnt_log[$];
  int   rsp_id_log[$];
  int   rsp_cyc_log[$];
  logic [XLEN-1:0] rsp_dat_log[$];
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   last_m = 1'b1;
  bit   take0 = 1'b0;
  bit   take1 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b1100: return ~(a | b);
      default: return {XLEN{1'bx}};
    endcase
  endfunction

  function automatic bit legal_op(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  endfunction

  function automatic op_t mk(input logic [3:0] op, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b);
    op_t o;
    o.op = op;
    o.a  = a;
    o.b  = b;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    case ($urandom_range(0, 5))
      0: o.op = ALU_AND;
      1: o.op = ALU_OR;
      2: o.op = ALU_ADD;
      3: o.op = ALU_SUB;
      4: o.op = ALU_SLT;
      default: o.op = ALU_NOR;
    endcase
`ifdef ALU_ARB_OPCHECK_EN
    if ($urandom_range(0, 9) == 0) o.op = 4'b1011;
`endif
    o.a = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: o.b = o.a;
      1: o.b = {32'h0, $urandom()};
      default: o.b = {$urandom(), $urandom()};
    endcase
    return o;
  endfunction

  // external ALU
  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = ref_alu(bus.alu_op, bus.alu_in1, bus.alu_in2);
    bus.alu_out = alu_res;
    bus.alu_zflag = (alu_res == {XLEN{1'b0}});
  end

  // requester driver: presents queue heads, retires them after a handshake
  initial begin
    bus.req_valid = 2'b00;
    bus.req_op0 = 4'b0000; bus.req_a0 = '0; bus.req_b0 = '0;
    bus.req_op1 = 4'b0000; bus.req_a1 = '0; bus.req_b1 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (take0 && src0.size() > 0) src0.delete(0);
      if (take1 && src1.size() > 0) src1.delete(0);
      take0 = 1'b0;
      take1 = 1'b0;
      if (src0.size() > 0) begin
        bus.req_valid[0] = 1'b1;
        bus.req_op0 = src0[0].op; bus.req_a0 = src0[0].a; bus.req_b0 = src0[0].b;
      end else begin
        bus.req_valid[0] = 1'b0;
      end
      if (src1.size() > 0) begin
        bus.req_valid[1] = 1'b1;
        bus.req_op1 = src1[0].op; bus.req_a1 = src1[0].a; bus.req_b1 = src1[0].b;
      end else begin
        bus.req_valid[1] = 1'b0;
      end
    end
  end

  // scoreboard: occupancy < 2 means a slot is free; a response is visible 2 cycles
  // after its handshake, or the cycle after its predecessor was taken
  logic [1:0] m_v, m_exp_rv, m_exp_rdy;
  bit   m_vis, m_del, m_acc;
  exp_t m_e;
  op_t  m_o;
  initial forever begin
    @(negedge clk);
    cyc = cyc + 1;
    if (mon_en) begin
      m_v = bus.req_valid;
      m_vis = (sb.size() > 0) && (cyc >= sb[0].vis);
      m_exp_rv = 2'b00;
      if (m_vis) m_exp_rv = sb[0].id ? 2'b10 : 2'b01;
      m_del = m_vis && bus.rsp_ready[sb[0].id];
      m_acc = (sb.size() < 2) || m_del;
      m_exp_rdy = 2'b00;
      if (m_acc) begin
        if (m_v == 2'b01) m_exp_rdy = 2'b01;
        else if (m_v == 2'b10) m_exp_rdy = 2'b10;
        else if (m_v == 2'b11) m_exp_rdy = last_m ? 2'b01 : 2'b10;
      end
      checks++;
      if (bus.rsp_valid !== m_exp_rv) begin
        errors++;
        $display("FAIL sb_rsp_valid cyc=%0d got=%b expected=%b", cyc, bus.rsp_valid, m_exp_rv);
      end
      checks++;
      if (bus.req_ready !== m_exp_rdy) begin
        errors++;
        $display("FAIL sb_req_ready cyc=%0d got=%b expected=%b", cyc, bus.req_ready, m_exp_rdy);
      end
      if (m_vis) begin
        checks++;
        if (bus.rsp_err !== sb[0].err) begin
          errors++;
          $display("FAIL sb_rsp_err cyc=%0d got=%b expected=%b", cyc, bus.rsp_err, sb[0].err);
        end
        if (!sb[0].xdata) begin
          checks++;
          if (bus.rsp_data !== sb[0].data) begin
            errors++;
            $display("FAIL sb_rsp_data cyc=%0d got=%h expected=%h", cyc, bus.rsp_data, sb[0].data);
          end
          checks++;
          if (bus.rsp_zero !== sb[0].zero) begin
            errors++;
            $display("FAIL sb_rsp_zero cyc=%0d got=%b expected=%b", cyc, bus.rsp_zero, sb[0].zero);
          end
        end
      end
      if (m_del) begin
        rsp_id_log.push_back(int'(sb[0].id));
        rsp_cyc_log.push_back(cyc);
        rsp_dat_log.push_back(bus.rsp_data);
        sb.delete(0);
        if (sb.size() > 0 && sb[0].vis < cyc + 1) begin
          m_e = sb[0];
          m_e.vis = cyc + 1;
          sb[0] = m_e;
        end
      end
      if (m_exp_rdy != 2'b00) begin
        if (m_exp_rdy[1]) begin
          m_o = mk(bus.req_op1, bus.req_a1, bus.req_b1);
          m_e.id = 1'b1; take1 = 1'b1; last_m = 1'b1; gnt_log.push_back(1);
        end else begin
          m_o = mk(bus.req_op0, bus.req_a0, bus.req_b0);
          m_e.id = 1'b0; take0 = 1'b1; last_m = 1'b0; gnt_log.push_back(0);
        end
        m_e.vis = cyc + 2;
        if (legal_op(m_o.op)) begin
          m_e.data = ref_alu(m_o.op, m_o.a, m_o.b);
          m_e.zero = (m_e.data == {XLEN{1'b0}});
          m_e.err = 1'b0; m_e.xdata = 1'b0;
        end else begin
`ifdef ALU_ARB_OPCHECK_EN
          m_e.data = {XLEN{1'b0}}; m_e.zero = 1'b1; m_e.err = 1'b1; m_e.xdata = 1'b0;
`else
          m_e.data = {XLEN{1'b0}}; m_e.zero = 1'b0; m_e.err = 1'b0; m_e.xdata = 1'b1;
`endif
        end
        sb.push_back(m_e);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || sb.size() > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain: still busy after %0d cycles, sb=%0d required 0", name, n, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b expected=00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b expected=00", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 64'd0) begin errors++; $display("FAIL reset_rsp_data got=%h expected=0", bus.rsp_data); end
    checks++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got=%b expected=0", bus.rsp_zero); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b expected=0", bus.rsp_err); end
    checks++; if (bus.alu_op !== 4'b0000) begin errors++; $display("FAIL reset_alu_op got=%b expected=0000", bus.alu_op); end
    checks++; if (bus.alu_in1 !== 64'd0) begin errors++; $display("FAIL reset_alu_in1 got=%h expected=0", bus.alu_in1); end
    checks++; if (bus.alu_in2 !== 64'd0) begin errors++; $display("FAIL reset_alu_in2 got=%h expected=0", bus.alu_in2); end
    @(posedge clk);
    #2;
    reset = 1'b0;
    last_m = 1'b1;
    sb.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_contention();
    gnt_log.delete();
    rsp_id_log.delete();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      src0.push_back(mk(ALU_ADD, 64'(i), 64'd100));
      src1.push_back(mk(ALU_SUB, 64'd1000, 64'(i)));
    end
    wait_idle("contention");
    checks++;
    if (gnt_log.size() != 8) begin errors++; $display("FAIL contention_count got=%0d expected=8", gnt_log.size()); end
    for (int i = 0; i < gnt_log.size() && i < 8; i++) begin
      checks++;
      if (gnt_log[i] != i % 2) begin errors++; $display("FAIL contention_grant[%0d] got=%0d expected=%0d", i, gnt_log[i], i % 2); end
      checks++;
      if (rsp_id_log[i] != i % 2) begin errors++; $display("FAIL contention_rsp_id[%0d] got=%0d expected=%0d", i, rsp_id_log[i], i % 2); end
    end
  endtask

  task automatic test_single_add();
    src0.push_back(mk(ALU_ADD, 64'd5, 64'd7));
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL add_req_ready got=%b expected=01", bus.req_ready); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL add_early_rsp got=%b expected=00", bus.rsp_valid); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got=%b expected=01", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 64'd12) begin errors++; $display("FAIL add_rsp_data got=%h expected=c", bus.rsp_data); end
    checks++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL add_rsp_zero got=%b expected=0", bus.rsp_zero); end
    wait_idle("single_add");
  endtask

  task automatic test_backpressure();
    int n;
    int base;
    base = rsp_id_log.size();
    @(posedge clk);
    #2;
    bus.rsp_ready = 2'b01;
    src1.push_back(mk(ALU_SUB, 64'd9, 64'd9));
    n = 0;
    do begin @(negedge clk); n++; end while (bus.req_ready !== 2'b10 && n < 10);
    checks++;
    if (n >= 10) begin errors++; $display("FAIL bp_sub_grant got=%b expected=10", bus.req_ready); end
    src0.push_back(mk(ALU_ADD, 64'd1, 64'd2));
    src1.push_back(mk(ALU_OR, 64'd4, 64'd8));
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_rsp_valid[%0d] got=%b expected=10", j, bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 64'd0) begin errors++; $display("FAIL bp_rsp_data[%0d] got=%h expected=0", j, bus.rsp_data); end
      checks++; if (bus.rsp_zero !== 1'b1) begin errors++; $display("FAIL bp_rsp_zero[%0d] got=%b expected=1", j, bus.rsp_zero); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_req_ready[%0d] got=%b expected=00", j, bus.req_ready); end
    end
    @(posedge clk);
    #2;
    bus.rsp_ready = 2'b11;
    wait_idle("backpressure");
    checks++;
    if (rsp_id_log.size() - base != 3) begin errors++; $display("FAIL bp_delivered got=%0d expected=3", rsp_id_log.size() - base); end
    else begin
      checks++;
      if (rsp_id_log[base] != 1 || rsp_id_log[base + 1] != 0 || rsp_id_log[base + 2] != 1)
        begin errors++; $display("FAIL bp_order got=%0d%0d%0d expected=101", rsp_id_log[base], rsp_id_log[base + 1], rsp_id_log[base + 2]); end
    end
  endtask

  task automatic test_streaming();
    logic [XLEN-1:0] exp_d [4];
    exp_d[0] = 64'h0000_0000_0000_F000;
    exp_d[1] = 64'h0000_0000_0000_FFFF;
    exp_d[2] = 64'd1;
    exp_d[3] = {XLEN{1'b1}};
    rsp_dat_log.delete();
    rsp_cyc_log.delete();
    src0.push_back(mk(ALU_AND, 64'hF0F0, 64'hFF00));
    src0.push_back(mk(ALU_OR, 64'hF0F0, 64'h0F0F));
    src0.push_back(mk(ALU_SLT, 64'd3, 64'd8));
    src0.push_back(mk(ALU_NOR, 64'd0, 64'd0));
    wait_idle("streaming");
    checks++;
    if (rsp_dat_log.size() != 4) begin errors++; $display("FAIL stream_count got=%0d expected=4", rsp_dat_log.size()); end
    for (int i = 0; i < rsp_dat_log.size() && i < 4; i++) begin
      checks++;
      if (rsp_dat_log[i] !== exp_d[i]) begin errors++; $display("FAIL stream_data[%0d] got=%h expected=%h", i, rsp_dat_log[i], exp_d[i]); end
      if (i > 0) begin
        checks++;
        if (rsp_cyc_log[i] - rsp_cyc_log[i - 1] != 1)
          begin errors++; $display("FAIL stream_gap[%0d] got=%0d expected=1", i, rsp_cyc_log[i] - rsp_cyc_log[i - 1]); end
      end
    end
  endtask

  task automatic test_illegal();
    int n;
    src0.push_back(mk(4'b0011, 64'd1, 64'd2));
    n = 0;
    do begin @(negedge clk); n++; end while (bus.rsp_valid !== 2'b01 && n < 10);
    checks++;
    if (n >= 10) begin errors++; $display("FAIL illegal_rsp_valid got=%b expected=01", bus.rsp_valid); end
`ifdef ALU_ARB_OPCHECK_EN
    checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b expected=1", bus.rsp_err); end
    checks++; if (bus.rsp_data !== 64'd0) begin errors++; $display("FAIL illegal_data got=%h expected=0", bus.rsp_data); end
    checks++; if (bus.rsp_zero !== 1'b1) begin errors++; $display("FAIL illegal_zero got=%b expected=1", bus.rsp_zero); end
`else
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL illegal_err got=%b expected=0", bus.rsp_err); end
`endif
    wait_idle("illegal");
  endtask

  task automatic test_random();
    int base;
    int pushed;
    base = rsp_id_log.size();
    pushed = 0;
    repeat (400) begin
      @(posedge clk);
      #2;
      bus.rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      if (src0.size() < 3 && $urandom_range(0, 2) != 0) begin src0.push_back(rand_op()); pushed++; end
      if (src1.size() < 3 && $urandom_range(0, 2) != 0) begin src1.push_back(rand_op()); pushed++; end
    end
    @(posedge clk);
    #2;
    bus.rsp_ready = 2'b11;
    wait_idle("random");
    checks++;
    if (rsp_id_log.size() - base != pushed)
      begin errors++; $display("FAIL random_delivered got=%0d expected=%0d", rsp_id_log.size() - base, pushed); end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk);
    #2;
    bus.rsp_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      src0.push_back(mk(ALU_ADD, 64'(i), 64'd1));
      src1.push_back(mk(ALU_OR, 64'(i), 64'd2));
    end
    repeat (6) @(negedge clk);
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL midrst_full_ready got=%b expected=00", bus.req_ready); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_rsp_valid got=%b expected=00", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL midrst_req_ready got=%b expected=00", bus.req_ready); end
    checks++; if (bus.rsp_data !== 64'd0) begin errors++; $display("FAIL midrst_rsp_data got=%h expected=0", bus.rsp_data); end
    src0.delete();
    src1.delete();
    sb.delete();
    gnt_log.delete();
    take0 = 1'b0;
    take1 = 1'b0;
    src0.push_back(mk(ALU_ADD, 64'd2, 64'd3));
    src1.push_back(mk(ALU_ADD, 64'd4, 64'd5));
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.rsp_ready = 2'b11;
    last_m = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL midrst_first_grant got=%b expected=01", bus.req_ready); end
    wait_idle("midrst");
  endtask

  initial begin
    reset = 1'b1;
    bus.rsp_ready = 2'b11;
    test_reset();
    test_contention();
    test_single_add();
    test_backpressure();
    test_streaming();
    test_illegal();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
